// File: rtl/hex_display_mux.sv
// Multiplexed N-digit hex seven-segment driver with built-in scan timing, frame-synchronous
// double buffering, PWM brightness, leading-zero blanking and per-digit decimal points.
module hex_display_mux #(
    parameter int DIGITS    = 4,
    parameter int SLOT_LOG2 = 10,
    parameter int PWM_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  data_we,
    input  logic [PWM_W-1:0]      brightness,
    input  logic                  lz_blank,
    output logic [DIGITS-1:0]     anodes,
    output logic [6:0]            segments,
    output logic                  dp,
    output logic                  frame_start
);

    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(DIGITS - 1);

    logic [SLOT_LOG2-1:0] slot_cnt;
    logic [DIG_W-1:0]     dig;
    logic                 slot_wrap;
    logic                 frame_end;

    logic [4*DIGITS-1:0]  pend_data;
    logic [DIGITS-1:0]    pend_dp;
    logic                 pend_valid;
    logic [4*DIGITS-1:0]  shadow_data;
    logic [DIGITS-1:0]    shadow_dp;
    logic [PWM_W-1:0]     br_sh;
    logic                 lz_sh;

    logic [PWM_W-1:0]     phase;
    logic                 lit;
    logic [3:0]           cur_nib;
    logic                 cur_dp;
    logic                 cur_blank;
    logic [DIGITS-1:0]    blank_mask;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0: seg7 = 7'b1111110;
            4'h1: seg7 = 7'b0110000;
            4'h2: seg7 = 7'b1101101;
            4'h3: seg7 = 7'b1111001;
            4'h4: seg7 = 7'b0110011;
            4'h5: seg7 = 7'b1011011;
            4'h6: seg7 = 7'b1011111;
            4'h7: seg7 = 7'b1110000;
            4'h8: seg7 = 7'b1111111;
            4'h9: seg7 = 7'b1111011;
            4'hA: seg7 = 7'b1110111;
            4'hB: seg7 = 7'b0011111;
            4'hC: seg7 = 7'b1001110;
            4'hD: seg7 = 7'b0111101;
            4'hE: seg7 = 7'b1001111;
            default: seg7 = 7'b1000111;
        endcase
    endfunction

    assign slot_wrap = &slot_cnt;
    assign frame_end = slot_wrap && (dig == LAST_DIG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            dig      <= '0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
            if (slot_wrap) begin
                dig <= (dig == LAST_DIG) ? '0 : dig + 1'b1;
            end
        end
    end

    // Shadow takes the older pending value at the boundary; a same-cycle write re-arms pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_data   <= '0;
            pend_dp     <= '0;
            pend_valid  <= 1'b0;
            shadow_data <= '0;
            shadow_dp   <= '0;
            br_sh       <= '1;
            lz_sh       <= 1'b0;
        end else begin
            if (frame_end) begin
                if (pend_valid) begin
                    shadow_data <= pend_data;
                    shadow_dp   <= pend_dp;
                end
                br_sh <= brightness;
                lz_sh <= lz_blank;
            end
            if (data_we) begin
                pend_data  <= data_in;
                pend_dp    <= dp_in;
                pend_valid <= 1'b1;
            end else if (frame_end) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // A digit is blank when it and every more-significant nibble are zero; digit 0 always shows.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        blank_mask = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (shadow_data[4*i +: 4] == 4'd0);
            if (i != 0) begin
                blank_mask[i] = lz_sh & upper_zero;
            end
        end
    end

    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig == DIG_W'(i)) begin
                cur_nib   = shadow_data[4*i +: 4];
                cur_dp    = shadow_dp[i];
                cur_blank = blank_mask[i];
            end
        end
    end

    assign phase = slot_cnt[SLOT_LOG2-1 -: PWM_W];
    assign lit   = (phase < br_sh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anodes      <= '0;
            segments    <= '0;
            dp          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            anodes      <= lit ? (DIGITS'(1) << dig) : '0;
            segments    <= (lit && !cur_blank) ? seg7(cur_nib) : 7'd0;
            dp          <= lit && !cur_blank && cur_dp;
            frame_start <= (dig == '0) && (slot_cnt == '0);
        end
    end

endmodule

// File: tb/tb_hex_display_mux.sv
// Self-checking bench for hex_display_mux: directed scenarios plus random traffic, all
// compared cycle by cycle against a frame-position arithmetic model.
`timescale 1ns/1ps
module tb_hex_display_mux;

    logic        clk;
    logic        rst_n;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        data_we;
    logic [1:0]  brightness;
    logic        lz_blank;
    logic [3:0]  anodes;
    logic [6:0]  segments;
    logic        dp;
    logic        frame_start;

    hex_display_mux #(.DIGITS(4), .SLOT_LOG2(4), .PWM_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in), .data_we(data_we),
        .brightness(brightness), .lz_blank(lz_blank), .anodes(anodes), .segments(segments),
        .dp(dp), .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_lut [0:15] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                   7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                   7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                   7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    // Reference state: cycles since reset release, pending/shown buffers and frame settings.
    int          cyc;
    int          last_pos;
    int          total_cyc;
    int          last_fs_cyc;
    logic [15:0] m_pend, m_shadow;
    logic [3:0]  m_pdp, m_sdp;
    logic        m_pv;
    int          m_br;
    logic        m_lz;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_fs;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", tag, obs, expv, $time);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [15:0] d, input logic [3:0] p);
        data_we = we;
        data_in = d;
        dp_in   = p;
    endtask

    task automatic model_reset();
        cyc = 0; last_pos = -1; last_fs_cyc = -1;
        m_pend = '0; m_shadow = '0; m_pdp = '0; m_sdp = '0; m_pv = 1'b0;
        m_br = 3; m_lz = 1'b0;
    endtask

    // Outputs after edge number cyc display frame position cyc mod 64.
    task automatic model_edge();
        int pos, d, ph;
        logic [15:0] upper;
        pos = cyc % 64; d = pos / 16; ph = (pos % 16) / 4;
        exp_an = '0; exp_seg = '0; exp_dp = 1'b0;
        if (ph < m_br) begin
            exp_an = 4'(1 << d);
            upper  = m_shadow >> (4 * d);
            if (!(m_lz && d > 0 && upper == 16'd0)) begin
                exp_seg = seg_lut[upper[3:0]];
                exp_dp  = m_sdp[d];
            end
        end
        exp_fs = (pos == 0);
        if (pos == 63) begin
            if (m_pv) begin
                m_shadow = m_pend; m_sdp = m_pdp; m_pv = 1'b0;
            end
            m_br = int'(brightness);
            m_lz = lz_blank;
        end
        if (data_we) begin
            m_pend = data_in; m_pdp = dp_in; m_pv = 1'b1;
        end
        last_pos = pos;
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        total_cyc++;
        checkOutput("anodes", 32'(anodes), 32'(exp_an));
        checkOutput("segments", 32'(segments), 32'(exp_seg));
        checkOutput("dp", 32'(dp), 32'(exp_dp));
        checkOutput("frame_start", 32'(frame_start), 32'(exp_fs));
        if (frame_start) begin
            if (last_fs_cyc >= 0) checkOutput("fs_period", 32'(total_cyc - last_fs_cyc), 32'd64);
            last_fs_cyc = total_cyc;
        end
    endtask

    task automatic run_until(input int p);
        int n;
        n = 0;
        while (last_pos != p && n < 200) begin
            step();
            n++;
        end
        checkOutput("run_until", 32'(last_pos), 32'(p));
    endtask

    task automatic count_slot(input int s, output int n);
        run_until(s * 16);
        n = 0;
        for (int k = 0; k < 16; k++) begin
            if (anodes != 4'd0) n++;
            if (k < 15) step();
        end
    endtask

    initial begin
        int n;
        total_cyc = 0;
        rst_n = 1'b0; brightness = 2'd3; lz_blank = 1'b0;
        applyStimulus(1'b0, 16'h0, 4'h0);
        model_reset();

        // Reset and defaults
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_anodes", 32'(anodes), 32'd0);
            checkOutput("rst_segments", 32'(segments), 32'd0);
            checkOutput("rst_dp_fs", 32'({dp, frame_start}), 32'd0);
        end
        rst_n = 1'b1;
        count_slot(0, n);
        checkOutput("default_lit", 32'(n), 32'd12);
        run_until(0);
        run_until(0);

        // Double buffering
        run_until(20);
        applyStimulus(1'b1, 16'h1A2F, 4'h0); step(); applyStimulus(1'b0, 16'h0, 4'h0);
        run_until(32);
        checkOutput("old_frame_seg", 32'(segments), 32'h7E);
        run_until(0);
        checkOutput("d0_F", 32'({anodes, segments}), 32'({4'b0001, 7'b1000111}));
        run_until(16);
        checkOutput("d1_2", 32'({anodes, segments}), 32'({4'b0010, 7'b1101101}));
        run_until(32);
        checkOutput("d2_A", 32'({anodes, segments}), 32'({4'b0100, 7'b1110111}));
        run_until(48);
        checkOutput("d3_1", 32'({anodes, segments}), 32'({4'b1000, 7'b0110000}));
        run_until(10);
        applyStimulus(1'b1, 16'h1111, 4'h0); step(); applyStimulus(1'b0, 16'h0, 4'h0);
        run_until(40);
        applyStimulus(1'b1, 16'h2222, 4'h0); step(); applyStimulus(1'b0, 16'h0, 4'h0);
        run_until(0);
        checkOutput("last_write_d0", 32'(segments), 32'({7'b1101101}));
        run_until(48);
        checkOutput("last_write_d3", 32'(segments), 32'({7'b1101101}));

        // Boundary-cycle write
        run_until(20);
        applyStimulus(1'b1, 16'h00AB, 4'h0); step(); applyStimulus(1'b0, 16'h0, 4'h0);
        run_until(62);
        applyStimulus(1'b1, 16'h5C3E, 4'h0); step(); applyStimulus(1'b0, 16'h0, 4'h0);
        run_until(0);
        checkOutput("bnd_b", 32'(segments), 32'({7'b0011111}));
        run_until(16);
        checkOutput("bnd_A", 32'(segments), 32'({7'b1110111}));
        run_until(0);
        checkOutput("bnd_E", 32'(segments), 32'({7'b1001111}));
        run_until(48);
        checkOutput("bnd_5", 32'(segments), 32'({7'b1011011}));

        // Brightness
        run_until(20); brightness = 2'd0;
        run_until(0);
        count_slot(1, n); checkOutput("br0_lit", 32'(n), 32'd0);
        brightness = 2'd1;
        run_until(0);
        count_slot(2, n); checkOutput("br1_lit", 32'(n), 32'd4);
        brightness = 2'd2;
        run_until(0);
        count_slot(0, n); checkOutput("br2_lit", 32'(n), 32'd8);
        brightness = 2'd3;
        count_slot(2, n); checkOutput("br_midframe", 32'(n), 32'd8);
        count_slot(0, n); checkOutput("br3_lit", 32'(n), 32'd12);

        // Leading-zero blanking
        run_until(20); lz_blank = 1'b1;
        applyStimulus(1'b1, 16'h0030, 4'h0); step(); applyStimulus(1'b0, 16'h0, 4'h0);
        run_until(0);
        checkOutput("lz_d0", 32'(segments), 32'({7'b1111110}));
        run_until(16);
        checkOutput("lz_d1", 32'(segments), 32'({7'b1111001}));
        run_until(32);
        checkOutput("lz_d2", 32'({anodes, segments}), 32'({4'b0100, 7'b0}));
        run_until(48);
        checkOutput("lz_d3", 32'({anodes, segments}), 32'({4'b1000, 7'b0}));
        run_until(20);
        applyStimulus(1'b1, 16'h0000, 4'b1000); step(); applyStimulus(1'b0, 16'h0, 4'h0);
        run_until(0);
        checkOutput("lz0_d0", 32'(segments), 32'({7'b1111110}));
        run_until(16);
        checkOutput("lz0_d1", 32'(segments), 32'd0);
        run_until(48);
        checkOutput("lz0_d3_dp", 32'({dp, segments}), 32'd0);
        lz_blank = 1'b0;

        // Reset mid-operation with pending data
        run_until(30);
        applyStimulus(1'b1, 16'hBEEF, 4'hF); step(); applyStimulus(1'b0, 16'h0, 4'h0);
        run_until(37);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_anodes", 32'(anodes), 32'd0);
        checkOutput("async_seg_dp_fs", 32'({segments, dp, frame_start}), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        checkOutput("fs_after_rst", 32'(frame_start), 32'd1);
        run_until(16);
        checkOutput("rst_discard", 32'(segments), 32'({7'b1111110}));

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            applyStimulus(($urandom % 16) == 0, 16'($urandom) >> ($urandom % 17), 4'($urandom));
            if ($urandom % 64 == 0) brightness = 2'($urandom);
            if ($urandom % 128 == 0) lz_blank = 1'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
